lcd_capture: RTL and testbench

Pixel-capture stage fed by the LCD-input synchronizers. It oversamples the already-synchronized LCD pixel clock, sync and data lines in the system clock domain and detects pixel-clock rising edges. It tracks line and pixel position and emits one frame-buffer write per active pixel. It also flags frame boundaries and timing errors.

---
 rtl/lcd_capture.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// lcd_capture: oversamples an already-synchronized LCD parallel interface in the
// system clock domain, tracks line/pixel position from the sync pulses and
// emits one frame-buffer write per active pixel, plus frame and error pulses.
module lcd_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int H_START    = 40,
    parameter int H_ACTIVE   = 480,
    parameter int V_START    = 8,
    parameter int V_ACTIVE   = 272
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lcd_pclk,
    input  logic                  i_lcd_hsync_n,
    input  logic                  i_lcd_vsync_n,
    input  logic [DATA_WIDTH-1:0] i_lcd_data,
    output logic                  o_wr_en,
    output logic [X_WIDTH-1:0]    o_wr_x,
    output logic [Y_WIDTH-1:0]    o_wr_y,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_frame_start,
    output logic                  o_frame_done,
    output logic                  o_err
);

    // Counters carry two guard bits so a runaway line or frame saturates well
    // past the active window instead of wrapping back into it.
    localparam int PW = X_WIDTH + 2;
    localparam int LW = Y_WIDTH + 2;

    localparam logic [PW-1:0] PIX_FIRST  = PW'(H_START);
    localparam logic [PW-1:0] PIX_LAST   = PW'(H_START + H_ACTIVE - 1);
    localparam logic [LW-1:0] LINE_FIRST = LW'(V_START);
    localparam logic [LW-1:0] LINE_END   = LW'(V_START + V_ACTIVE);
    localparam logic [LW-1:0] LINE_LAST  = LW'(V_START + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_VBLANK  = 2'd1,
        S_HBLANK  = 2'd2,
        S_ACTIVE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    pclk_q, pclk_d;
    logic                    hs_q, hs_d;
    logic                    vs_q, vs_d;
    logic [PW-1:0]           pix_cnt_q, pix_cnt_d, pix_next;
    logic [LW-1:0]           line_cnt_q, line_cnt_d, line_next;
    logic                    wr_en_q, wr_en_d;
    logic [X_WIDTH-1:0]      wr_x_q, wr_x_d;
    logic [Y_WIDTH-1:0]      wr_y_q, wr_y_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    frame_start_q, frame_start_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_q, err_d;

    logic rise, hs_fall, vs_fall, hs_take, line_active, take_pixel;

    // Detect pixel-clock rises and qualify sync falls; sync lines are only
    // resampled on a rise so their history follows the pixel clock.
    always_comb begin
        rise    = i_lcd_pclk & ~pclk_q;
        hs_fall = rise & hs_q & ~i_lcd_hsync_n;
        vs_fall = rise & vs_q & ~i_lcd_vsync_n;
        hs_take = hs_fall & ~vs_fall;
        pclk_d  = i_lcd_pclk;
        hs_d    = rise ? i_lcd_hsync_n : hs_q;
        vs_d    = rise ? i_lcd_vsync_n : vs_q;
    end

    // Saturating position counters; pix_next/line_next are the values that
    // belong to the current rise, so pixel decisions use them directly.
    always_comb begin
        if (hs_take)
            pix_next = '0;
        else if (pix_cnt_q == '1)
            pix_next = pix_cnt_q;
        else
            pix_next = pix_cnt_q + PW'(1);

        if (vs_fall)
            line_next = '0;
        else if (hs_take && (line_cnt_q != '1))
            line_next = line_cnt_q + LW'(1);
        else
            line_next = line_cnt_q;

        pix_cnt_d   = rise ? pix_next  : pix_cnt_q;
        line_cnt_d  = rise ? line_next : line_cnt_q;
        line_active = (line_next >= LINE_FIRST) && (line_next < LINE_END);
    end

    // Capture FSM: next state, write strobe and frame/error pulses, all
    // evaluated only on a pixel-clock rise.
    always_comb begin
        state_d       = state_q;
        take_pixel    = 1'b0;
        wr_en_d       = 1'b0;
        wr_x_d        = wr_x_q;
        wr_y_d        = wr_y_q;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;

        if (rise) begin
            if (vs_fall) begin
                state_d       = S_VBLANK;
                frame_start_d = 1'b1;
                err_d         = (state_q != S_WAIT_VS);
            end else begin
                case (state_q)
                    S_WAIT_VS: begin
                        state_d = S_WAIT_VS;
                    end
                    S_VBLANK, S_HBLANK, S_ACTIVE: begin
                        if (hs_take) begin
                            err_d = (state_q == S_ACTIVE);
                            if (!line_active)
                                state_d = S_VBLANK;
                            else if (H_START == 0)
                                take_pixel = 1'b1;
                            else
                                state_d = S_HBLANK;
                        end else if (state_q == S_ACTIVE) begin
                            take_pixel = 1'b1;
                        end else if ((state_q == S_HBLANK) && (pix_next == PIX_FIRST)) begin
                            take_pixel = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_WAIT_VS;
                    end
                endcase

                if (take_pixel) begin
                    wr_en_d   = 1'b1;
                    wr_x_d    = X_WIDTH'(pix_next - PIX_FIRST);
                    wr_y_d    = Y_WIDTH'(line_next - LINE_FIRST);
                    wr_data_d = i_lcd_data;
                    if (pix_next == PIX_LAST) begin
                        if (line_next == LINE_LAST) begin
                            state_d      = S_WAIT_VS;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = S_VBLANK;
                        end
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
            end
        end
    end

    // State and output registers; reset aborts any line or frame in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_WAIT_VS;
            pclk_q        <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_x_q        <= '0;
            wr_y_q        <= '0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pclk_q        <= pclk_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_x_q        <= wr_x_d;
            wr_y_q        <= wr_y_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_x        = wr_x_q;
    assign o_wr_y        = wr_y_q;
    assign o_wr_data     = wr_data_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_done  = frame_done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed frames on a tiny 4x2 active window; every expected
// write is queued as it is driven and matched when the DUT strobes it.
module tb_lcd_capture;

    localparam int DW = 16;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int H_ACTIVE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pclk = 1'b0;
    logic          hs_n = 1'b1;
    logic          vs_n = 1'b1;
    logic [DW-1:0] data = '0;

    logic          o_wr_en;
    logic [XW-1:0] o_wr_x;
    logic [YW-1:0] o_wr_y;
    logic [DW-1:0] o_wr_data;
    logic          o_frame_start;
    logic          o_frame_done;
    logic          o_err;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [DW-1:0] d;
        logic          done;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int total = 0;
    int bad = 0;
    int n_start = 0, n_done = 0, n_err = 0, n_both = 0;
    int exp_start = 0, exp_done = 0, exp_err = 0, exp_both = 0;
    logic prev_wr = 1'b0, prev_start = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

    lcd_capture #(
        .DATA_WIDTH(DW),
        .X_WIDTH   (XW),
        .Y_WIDTH   (YW),
        .H_START   (2),
        .H_ACTIVE  (H_ACTIVE),
        .V_START   (1),
        .V_ACTIVE  (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_lcd_pclk   (pclk),
        .i_lcd_hsync_n(hs_n),
        .i_lcd_vsync_n(vs_n),
        .i_lcd_data   (data),
        .o_wr_en      (o_wr_en),
        .o_wr_x       (o_wr_x),
        .o_wr_y       (o_wr_y),
        .o_wr_data    (o_wr_data),
        .o_frame_start(o_frame_start),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still reports and ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of stimulus, required finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Monitor: pops the scoreboard on each write and tallies one-cycle pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_wr_en) begin
                checkOutput("wr_back_to_back", 32'(prev_wr), 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_write", 32'(o_wr_en), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("wr_x", 32'(o_wr_x), 32'(e.x));
                    checkOutput("wr_y", 32'(o_wr_y), 32'(e.y));
                    checkOutput("wr_data", 32'(o_wr_data), 32'(e.d));
                    checkOutput("wr_frame_done", 32'(o_frame_done), 32'(e.done));
                end
            end
            if (o_frame_start) begin
                n_start++;
                checkOutput("frame_start_width", 32'(prev_start), 32'd0);
            end
            if (o_frame_done) begin
                n_done++;
                checkOutput("done_with_write", 32'(o_wr_en), 32'd1);
                checkOutput("frame_done_width", 32'(prev_done), 32'd0);
            end
            if (o_err) begin
                n_err++;
                checkOutput("err_width", 32'(prev_err), 32'd0);
            end
            if (o_err && o_frame_start)
                n_both++;
        end
        prev_wr    = o_wr_en;
        prev_start = o_frame_start;
        prev_done  = o_frame_done;
        prev_err   = o_err;
    end

    // One pixel-clock period starting at a falling clock edge.
    task automatic applyStimulus(input logic hs, input logic vs, input logic [DW-1:0] d,
                                 input int low_cyc, input int high_cyc);
        hs_n = hs;
        vs_n = vs;
        data = d;
        pclk = 1'b0;
        repeat (low_cyc) @(negedge clk);
        pclk = 1'b1;
        repeat (high_cyc) @(negedge clk);
    endtask

    task automatic tick(input logic hs, input logic vs, input logic [DW-1:0] d);
        applyStimulus(hs, vs, d, 2, 2);
    endtask

    task automatic vs_tick();
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b1, 1'b1, 16'h0000);
    endtask

    task automatic push_pix(input int x, input int y, input logic [DW-1:0] d, input logic done);
        exp_t t;
        t.x = XW'(x);
        t.y = YW'(y);
        t.d = d;
        t.done = done;
        sb.push_back(t);
    endtask

    // hsync fall, one porch pixel, then n_pix data pixels from base upward.
    task automatic send_line(input int n_pix, input int y, input logic exp_wr,
                             input logic last_row, input logic [DW-1:0] base);
        tick(1'b0, 1'b1, 16'hFFFF);
        tick(1'b1, 1'b1, 16'hEEEE);
        for (int i = 0; i < n_pix; i++) begin
            if (exp_wr)
                push_pix(i, y, 16'(base + i), last_row && (i == H_ACTIVE - 1));
            tick(1'b1, 1'b1, 16'(base + i));
        end
        if (n_pix == H_ACTIVE) begin
            tick(1'b1, 1'b1, 16'h0000);
            tick(1'b1, 1'b1, 16'h0000);
        end
    endtask

    task automatic check_counts(input string scen);
        repeat (2) @(negedge clk);
        checkOutput({scen, "_frame_start_count"}, 32'(n_start), 32'(exp_start));
        checkOutput({scen, "_frame_done_count"}, 32'(n_done), 32'(exp_done));
        checkOutput({scen, "_err_count"}, 32'(n_err), 32'(exp_err));
        checkOutput({scen, "_err_with_start_count"}, 32'(n_both), 32'(exp_both));
        checkOutput({scen, "_pending_writes"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_en", 32'(o_wr_en), 32'd0);
        checkOutput("rst_wr_x", 32'(o_wr_x), 32'd0);
        checkOutput("rst_wr_y", 32'(o_wr_y), 32'd0);
        checkOutput("rst_wr_data", 32'(o_wr_data), 32'd0);
        checkOutput("rst_frame_start", 32'(o_frame_start), 32'd0);
        checkOutput("rst_frame_done", 32'(o_frame_done), 32'd0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, data 0..7.
        vs_tick();
        exp_start++;
        send_line(4, 0, 1'b1, 1'b0, 16'h0000);
        send_line(4, 1, 1'b1, 1'b1, 16'h0004);
        exp_done++;
        check_counts("full_frame");

        // Write latency, pulse width and a long pclk-high phase.
        vs_tick();
        exp_start++;
        tick(1'b0, 1'b1, 16'hFFFF);
        tick(1'b1, 1'b1, 16'hEEEE);
        push_pix(0, 0, 16'hA5A5, 1'b0);
        hs_n = 1'b1;
        data = 16'hA5A5;
        pclk = 1'b0;
        repeat (2) @(negedge clk);
        pclk = 1'b1;
        @(negedge clk);
        checkOutput("lat_wr_en_high", 32'(o_wr_en), 32'd1);
        checkOutput("lat_wr_data", 32'(o_wr_data), 32'hA5A5);
        checkOutput("lat_wr_x", 32'(o_wr_x), 32'd0);
        @(negedge clk);
        checkOutput("lat_wr_en_low", 32'(o_wr_en), 32'd0);
        checkOutput("lat_data_hold", 32'(o_wr_data), 32'hA5A5);
        @(negedge clk);
        checkOutput("lat_no_extra_write", 32'(o_wr_en), 32'd0);
        for (int i = 1; i < 4; i++) begin
            push_pix(i, 0, 16'(16'h0010 + i), 1'b0);
            tick(1'b1, 1'b1, 16'(16'h0010 + i));
        end
        tick(1'b1, 1'b1, 16'h0000);
        send_line(4, 1, 1'b1, 1'b1, 16'h0020);
        exp_done++;
        check_counts("latency");

        // Short line: hsync after 2 active pixels.
        vs_tick();
        exp_start++;
        send_line(2, 0, 1'b1, 1'b0, 16'h0030);
        send_line(4, 1, 1'b1, 1'b1, 16'h0040);
        exp_err++;
        exp_done++;
        check_counts("short_line");

        // Short frame: vsync in the middle of the second line.
        vs_tick();
        exp_start++;
        send_line(4, 0, 1'b1, 1'b0, 16'h0050);
        send_line(2, 1, 1'b1, 1'b0, 16'h0060);
        vs_tick();
        exp_start++;
        exp_err++;
        exp_both++;
        send_line(4, 0, 1'b1, 1'b0, 16'h0070);
        send_line(4, 1, 1'b1, 1'b1, 16'h0080);
        exp_done++;
        check_counts("short_frame");

        // Simultaneous vsync and hsync falls: the hsync must not count.
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b1, 16'h0000);
        exp_start++;
        send_line(4, 0, 1'b1, 1'b0, 16'h0090);
        send_line(4, 1, 1'b1, 1'b1, 16'h00A0);
        exp_done++;
        check_counts("vs_hs_same_rise");

        // Asynchronous reset during a write pulse, then recovery.
        vs_tick();
        exp_start++;
        tick(1'b0, 1'b1, 16'hFFFF);
        tick(1'b1, 1'b1, 16'hEEEE);
        push_pix(0, 0, 16'h0600, 1'b0);
        tick(1'b1, 1'b1, 16'h0600);
        push_pix(1, 0, 16'h0601, 1'b0);
        hs_n = 1'b1;
        data = 16'h0601;
        pclk = 1'b0;
        repeat (2) @(negedge clk);
        pclk = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        pclk = 1'b0;
        #1;
        checkOutput("arst_wr_en", 32'(o_wr_en), 32'd0);
        checkOutput("arst_wr_x", 32'(o_wr_x), 32'd0);
        checkOutput("arst_wr_data", 32'(o_wr_data), 32'd0);
        checkOutput("arst_err", 32'(o_err), 32'd0);
        checkOutput("arst_frame_done", 32'(o_frame_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_line(4, 0, 1'b0, 1'b0, 16'h0700);
        vs_tick();
        exp_start++;
        send_line(4, 0, 1'b1, 1'b0, 16'h0800);
        send_line(4, 1, 1'b1, 1'b1, 16'h0810);
        exp_done++;
        check_counts("reset_mid_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
